// File: rtl/tone_scheduler.sv
// Tune-table sequencer: fetches 8-bit note entries, times them in ms and drives the tone stage.
// Define TONE_SCHED_LOOP_EN to make a last-flagged entry restart the table instead of ending playback.
module tone_scheduler #(
  parameter int ADDR_W = 5,
  parameter int GAP_MS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       ticks_per_milli,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        pitch,
  output logic              note_on,
  output logic              note_strobe,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_GAP
  } state_t;

  localparam logic [11:0] GAP_LEN = 12'(GAP_MS);

  state_t      state;
  logic [15:0] presc;
  logic [11:0] ms_cnt;
  logic [2:0]  dur;
  logic        last;

  logic        ms_tick;
  logic        play_end;
  logic        gap_end;
  logic        entry_end;

  // A zero prescale would never tick, so it is clamped to one cycle per ms.
  function automatic logic [15:0] eff_ticks(input logic [15:0] t);
    return (t == 16'd0) ? 16'd1 : t;
  endfunction

  function automatic logic [11:0] play_len(input logic [2:0] d);
    return (12'd16 << d) - GAP_LEN;
  endfunction

  // >= rather than == so a live prescale decrease below the current count wraps at once.
  assign ms_tick   = (presc >= (eff_ticks(ticks_per_milli) - 16'd1));
  assign play_end  = (state == S_PLAY) && ms_tick && (ms_cnt == (play_len(dur) - 12'd1));
  assign gap_end   = (state == S_GAP) && ms_tick && (ms_cnt == (GAP_LEN - 12'd1));
  assign entry_end = gap_end || (play_end && (GAP_MS == 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rom_addr    <= '0;
      pitch       <= 4'd0;
      note_on     <= 1'b0;
      note_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      presc       <= 16'd0;
      ms_cnt      <= 12'd0;
      dur         <= 3'd0;
      last        <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      done        <= 1'b0;
      if ((state != S_IDLE) && stop) begin
        state   <= S_IDLE;
        pitch   <= 4'd0;
        note_on <= 1'b0;
        busy    <= 1'b0;
      end else if (entry_end) begin
        pitch   <= 4'd0;
        note_on <= 1'b0;
        if (last) begin
`ifdef TONE_SCHED_LOOP_EN
          rom_addr <= '0;
          state    <= S_FETCH;
`else
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
`endif
        end else begin
          rom_addr <= rom_addr + ADDR_W'(1);
          state    <= S_FETCH;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              state    <= S_FETCH;
              rom_addr <= '0;
              busy     <= 1'b1;
            end
          end
          S_FETCH: state <= S_LATCH;
          S_LATCH: begin
            dur         <= rom_data[3:1];
            last        <= rom_data[0];
            pitch       <= rom_data[7:4];
            note_on     <= |rom_data[7:4];
            note_strobe <= 1'b1;
            presc       <= 16'd0;
            ms_cnt      <= 12'd0;
            state       <= S_PLAY;
          end
          S_PLAY: begin
            if (ms_tick) begin
              presc <= 16'd0;
              if (play_end) begin
                state   <= S_GAP;
                ms_cnt  <= 12'd0;
                pitch   <= 4'd0;
                note_on <= 1'b0;
              end else begin
                ms_cnt <= ms_cnt + 12'd1;
              end
            end else begin
              presc <= presc + 16'd1;
            end
          end
          S_GAP: begin
            if (ms_tick) begin
              presc  <= 16'd0;
              ms_cnt <= ms_cnt + 12'd1;
            end else begin
              presc <= presc + 16'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
